// File: rtl/rename_alloc_ctrl.sv
// rename_alloc_ctrl: grants destination tags from the physical-register free
// list to up to four decode slots as an all-or-nothing group, forwards up to
// eight retire-time releases back into the free list, tracks free-list
// occupancy and blocks allocation during init, flush and recovery.
module rename_alloc_ctrl #(
   parameter int TAG_WIDTH = 5,
   parameter int NUM_TAGS  = 32,
   parameter int CNT_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 alloc_valid,
   input  logic [3:0]           alloc_req,
   output logic                 alloc_ready,
   output logic [TAG_WIDTH-1:0] alloc_tag0,
   output logic [TAG_WIDTH-1:0] alloc_tag1,
   output logic [TAG_WIDTH-1:0] alloc_tag2,
   output logic [TAG_WIDTH-1:0] alloc_tag3,
   output logic [3:0]           fl_rd_en,
   input  logic [TAG_WIDTH-1:0] fl_data0,
   input  logic [TAG_WIDTH-1:0] fl_data1,
   input  logic [TAG_WIDTH-1:0] fl_data2,
   input  logic [TAG_WIDTH-1:0] fl_data3,
   input  logic [7:0]           free_valid,
   input  logic [TAG_WIDTH-1:0] free_tag0,
   input  logic [TAG_WIDTH-1:0] free_tag1,
   input  logic [TAG_WIDTH-1:0] free_tag2,
   input  logic [TAG_WIDTH-1:0] free_tag3,
   input  logic [TAG_WIDTH-1:0] free_tag4,
   input  logic [TAG_WIDTH-1:0] free_tag5,
   input  logic [TAG_WIDTH-1:0] free_tag6,
   input  logic [TAG_WIDTH-1:0] free_tag7,
   output logic [7:0]           fl_wr_en,
   output logic [TAG_WIDTH-1:0] fl_wdata0,
   output logic [TAG_WIDTH-1:0] fl_wdata1,
   output logic [TAG_WIDTH-1:0] fl_wdata2,
   output logic [TAG_WIDTH-1:0] fl_wdata3,
   output logic [TAG_WIDTH-1:0] fl_wdata4,
   output logic [TAG_WIDTH-1:0] fl_wdata5,
   output logic [TAG_WIDTH-1:0] fl_wdata6,
   output logic [TAG_WIDTH-1:0] fl_wdata7,
   output logic [CNT_WIDTH-1:0] free_count,
   input  logic                 flush,
   output logic                 err_overflow
);

   typedef enum logic [2:0] {
      S_INIT,
      S_RUN,
      S_FLUSH,
      S_REC1,
      S_REC2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [TAG_WIDTH-1:0] head [4];
   logic [TAG_WIDTH-1:0] rel_tag [8];
   logic [TAG_WIDTH-1:0] tag [4];
   logic [TAG_WIDTH-1:0] wdata [8];

   logic [2:0]           n;
   logic [3:0]           m;
   logic                 grant;
   logic                 rel_ok;
   logic                 ovf;
   logic [CNT_WIDTH:0]   cnt_ext;
   logic [CNT_WIDTH:0]   n_granted;
   logic [CNT_WIDTH:0]   m_eff;
   logic [CNT_WIDTH:0]   sum;
   logic [CNT_WIDTH:0]   grant_only;
   logic [CNT_WIDTH-1:0] count_nxt;

   assign head[0] = fl_data0;
   assign head[1] = fl_data1;
   assign head[2] = fl_data2;
   assign head[3] = fl_data3;

   assign rel_tag[0] = free_tag0;
   assign rel_tag[1] = free_tag1;
   assign rel_tag[2] = free_tag2;
   assign rel_tag[3] = free_tag3;
   assign rel_tag[4] = free_tag4;
   assign rel_tag[5] = free_tag5;
   assign rel_tag[6] = free_tag6;
   assign rel_tag[7] = free_tag7;

   assign alloc_tag0 = tag[0];
   assign alloc_tag1 = tag[1];
   assign alloc_tag2 = tag[2];
   assign alloc_tag3 = tag[3];

   assign fl_wdata0 = wdata[0];
   assign fl_wdata1 = wdata[1];
   assign fl_wdata2 = wdata[2];
   assign fl_wdata3 = wdata[3];
   assign fl_wdata4 = wdata[4];
   assign fl_wdata5 = wdata[5];
   assign fl_wdata6 = wdata[6];
   assign fl_wdata7 = wdata[7];

   // State register, occupancy counter and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_INIT;
         free_count   <= CNT_WIDTH'(NUM_TAGS);
         err_overflow <= 1'b0;
      end else begin
         state      <= state_nxt;
         free_count <= count_nxt;
         if (ovf) begin
            err_overflow <= 1'b1;
         end
      end
   end

   // Next-state: INIT lasts one cycle; flush wins from every other state;
   // two recovery cycles follow the end of a flush.
   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:  state_nxt = S_RUN;
         S_RUN:   state_nxt = flush ? S_FLUSH : S_RUN;
         S_FLUSH: state_nxt = flush ? S_FLUSH : S_REC1;
         S_REC1:  state_nxt = flush ? S_FLUSH : S_REC2;
         S_REC2:  state_nxt = flush ? S_FLUSH : S_RUN;
         default: state_nxt = S_INIT;
      endcase
   end

   // Request and release population counts.
   always_comb begin
      n = '0;
      m = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         n = n + 3'(alloc_req[i]);
      end
      for (int unsigned j = 0; j < 8; j++) begin
         m = m + 4'(free_valid[j]);
      end
   end

   // Grant decision, count arithmetic (one spare bit so nothing wraps) and
   // overflow detection; an overflowing release is dropped but the grant
   // still takes effect.
   always_comb begin
      rel_ok     = !rst && (state != S_INIT);
      cnt_ext    = {1'b0, free_count};
      grant      = !rst && (state == S_RUN) && alloc_valid && (n != 3'd0) &&
                   (cnt_ext > (CNT_WIDTH+1)'(n));
      n_granted  = grant ? (CNT_WIDTH+1)'(n) : '0;
      m_eff      = rel_ok ? (CNT_WIDTH+1)'(m) : '0;
      grant_only = cnt_ext - n_granted;
      sum        = grant_only + m_eff;
      ovf        = rel_ok && (sum > (CNT_WIDTH+1)'(NUM_TAGS));
      count_nxt  = CNT_WIDTH'(ovf ? grant_only : sum);
   end

   // Allocation outputs: thermometer read enable and per-slot tag steering,
   // where slot i takes the head entry indexed by the requests below it.
   always_comb begin
      logic [2:0] k;
      k           = '0;
      alloc_ready = !rst && (state == S_RUN) && alloc_valid && ((n == 3'd0) || grant);
      fl_rd_en    = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         tag[i]      = '0;
         fl_rd_en[i] = grant && (i < 32'(n));
         if (alloc_req[i]) begin
            if (grant) begin
               tag[i] = head[k[1:0]];
            end
            k = k + 3'd1;
         end
      end
   end

   // Release outputs: pass sparse releases straight through unless blocked
   // by init/reset or dropped because of overflow.
   always_comb begin
      fl_wr_en = (rel_ok && !ovf) ? free_valid : '0;
      for (int unsigned j = 0; j < 8; j++) begin
         wdata[j] = (rel_ok && free_valid[j]) ? rel_tag[j] : '0;
      end
   end

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Directed, table-driven bench for rename_alloc_ctrl.
module tb_rename_alloc_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       alloc_valid;
   logic [3:0] alloc_req;
   logic       alloc_ready;
   logic [4:0] alloc_tag0, alloc_tag1, alloc_tag2, alloc_tag3;
   logic [3:0] fl_rd_en;
   logic [4:0] fl_data0, fl_data1, fl_data2, fl_data3;
   logic [7:0] free_valid;
   logic [4:0] free_tag0, free_tag1, free_tag2, free_tag3;
   logic [4:0] free_tag4, free_tag5, free_tag6, free_tag7;
   logic [7:0] fl_wr_en;
   logic [4:0] fl_wdata0, fl_wdata1, fl_wdata2, fl_wdata3;
   logic [4:0] fl_wdata4, fl_wdata5, fl_wdata6, fl_wdata7;
   logic [5:0] free_count;
   logic       flush;
   logic       err_overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rename_alloc_ctrl #(.TAG_WIDTH(5), .NUM_TAGS(32), .CNT_WIDTH(6)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
      .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
      .alloc_tag2(alloc_tag2), .alloc_tag3(alloc_tag3),
      .fl_rd_en(fl_rd_en),
      .fl_data0(fl_data0), .fl_data1(fl_data1), .fl_data2(fl_data2), .fl_data3(fl_data3),
      .free_valid(free_valid),
      .free_tag0(free_tag0), .free_tag1(free_tag1), .free_tag2(free_tag2), .free_tag3(free_tag3),
      .free_tag4(free_tag4), .free_tag5(free_tag5), .free_tag6(free_tag6), .free_tag7(free_tag7),
      .fl_wr_en(fl_wr_en),
      .fl_wdata0(fl_wdata0), .fl_wdata1(fl_wdata1), .fl_wdata2(fl_wdata2), .fl_wdata3(fl_wdata3),
      .fl_wdata4(fl_wdata4), .fl_wdata5(fl_wdata5), .fl_wdata6(fl_wdata6), .fl_wdata7(fl_wdata7),
      .free_count(free_count), .flush(flush), .err_overflow(err_overflow)
   );

   typedef struct {
      logic       av;
      logic [3:0] req;
      logic [7:0] fv;
      logic       fl;
      logic       rdy;
      logic [3:0] rd;
      logic [19:0] tags;   // {tag3, tag2, tag1, tag0}
      logic [7:0] wr;
      logic [5:0] cnt;     // free_count after the edge
      logic       err;     // err_overflow after the edge
   } vec_t;

   vec_t vecs[$];

   task automatic row(input logic av, input logic [3:0] req, input logic [7:0] fv,
                      input logic fl, input logic rdy, input logic [3:0] rd,
                      input logic [4:0] t0, input logic [4:0] t1,
                      input logic [4:0] t2, input logic [4:0] t3,
                      input logic [7:0] wr, input logic [5:0] cnt, input logic err);
      vec_t v;
      v.av = av; v.req = req; v.fv = fv; v.fl = fl; v.rdy = rdy; v.rd = rd;
      v.tags = {t3, t2, t1, t0}; v.wr = wr; v.cnt = cnt; v.err = err;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [39:0] exp_wdata(input logic [7:0] fv, input logic on);
      logic [39:0] r;
      r = '0;
      for (int j = 0; j < 8; j++) begin
         if (on && fv[j]) r[j*5 +: 5] = 5'(16 + j);
      end
      return r;
   endfunction

   initial begin
      // Fixed free-list head contents and release tags.
      fl_data0 = 5'd7;  fl_data1 = 5'd9;  fl_data2 = 5'd11; fl_data3 = 5'd13;
      free_tag0 = 5'd16; free_tag1 = 5'd17; free_tag2 = 5'd18; free_tag3 = 5'd19;
      free_tag4 = 5'd20; free_tag5 = 5'd21; free_tag6 = 5'd22; free_tag7 = 5'd23;

      //   av  req      fv            fl rdy rd       t0 t1 t2 t3  wr            cnt err
      row(1, 4'b1111, 8'b0000_0001, 0, 0, 4'b0000,  0, 0, 0, 0, 8'b0000_0000, 32, 0); // INIT
      row(1, 4'b0000, 8'b0000_0000, 0, 1, 4'b0000,  0, 0, 0, 0, 8'b0000_0000, 32, 0);
      row(0, 4'b1111, 8'b0000_0000, 0, 0, 4'b0000,  0, 0, 0, 0, 8'b0000_0000, 32, 0);
      row(1, 4'b1010, 8'b0000_0000, 0, 1, 4'b0011,  0, 7, 0, 9, 8'b0000_0000, 30, 0);
      row(1, 4'b1111, 8'b0000_0000, 0, 1, 4'b1111,  7, 9,11,13, 8'b0000_0000, 26, 0);
      row(1, 4'b0111, 8'b0000_0000, 0, 1, 4'b0111,  7, 9,11, 0, 8'b0000_0000, 23, 0);
      row(1, 4'b1001, 8'b0000_0000, 0, 1, 4'b0011,  7, 0, 0, 9, 8'b0000_0000, 21, 0);
      row(1, 4'b1111, 8'b0000_0000, 0, 1, 4'b1111,  7, 9,11,13, 8'b0000_0000, 17, 0);
      row(1, 4'b1111, 8'b0000_0000, 0, 1, 4'b1111,  7, 9,11,13, 8'b0000_0000, 13, 0);
      row(1, 4'b1111, 8'b0000_0000, 0, 1, 4'b1111,  7, 9,11,13, 8'b0000_0000,  9, 0);
      row(1, 4'b0100, 8'b0000_0000, 0, 1, 4'b0001,  0, 0, 7, 0, 8'b0000_0000,  8, 0);
      row(1, 4'b1111, 8'b0000_0000, 0, 1, 4'b1111,  7, 9,11,13, 8'b0000_0000,  4, 0);
      row(1, 4'b1111, 8'b0000_0000, 0, 0, 4'b0000,  0, 0, 0, 0, 8'b0000_0000,  4, 0); // 4 > 4 fails
      row(1, 4'b0111, 8'b0000_0001, 0, 1, 4'b0111,  7, 9,11, 0, 8'b0000_0001,  2, 0);
      row(0, 4'b0000, 8'b0000_0111, 0, 0, 4'b0000,  0, 0, 0, 0, 8'b0000_0111,  5, 0);
      row(1, 4'b1111, 8'b0000_0000, 0, 1, 4'b1111,  7, 9,11,13, 8'b0000_0000,  1, 0); // 5 > 4
      row(1, 4'b0001, 8'b0000_1001, 0, 0, 4'b0000,  0, 0, 0, 0, 8'b0000_1001,  3, 0); // 1 > 1 fails
      row(1, 4'b0011, 8'b0000_0000, 0, 1, 4'b0011,  7, 9, 0, 0, 8'b0000_0000,  1, 0);
      row(0, 4'b0000, 8'b1111_1111, 0, 0, 4'b0000,  0, 0, 0, 0, 8'b1111_1111,  9, 0);
      row(0, 4'b0000, 8'b0000_0001, 0, 0, 4'b0000,  0, 0, 0, 0, 8'b0000_0001, 10, 0);
      row(1, 4'b1101, 8'b1000_0101, 0, 1, 4'b0111,  7, 0, 9,11, 8'b1000_0101, 10, 0); // netting
      row(0, 4'b0000, 8'b1111_1111, 0, 0, 4'b0000,  0, 0, 0, 0, 8'b1111_1111, 18, 0);
      row(0, 4'b0000, 8'b1111_1111, 0, 0, 4'b0000,  0, 0, 0, 0, 8'b1111_1111, 26, 0);
      row(0, 4'b0000, 8'b0001_1111, 0, 0, 4'b0000,  0, 0, 0, 0, 8'b0001_1111, 31, 0);
      row(0, 4'b0000, 8'b0000_0011, 0, 0, 4'b0000,  0, 0, 0, 0, 8'b0000_0000, 31, 1); // overflow
      row(0, 4'b0000, 8'b0000_0001, 0, 0, 4'b0000,  0, 0, 0, 0, 8'b0000_0001, 32, 1);
      row(1, 4'b0001, 8'b0000_0001, 0, 1, 4'b0001,  7, 0, 0, 0, 8'b0000_0001, 32, 1);
      row(1, 4'b0001, 8'b0000_0011, 0, 1, 4'b0001,  7, 0, 0, 0, 8'b0000_0000, 31, 1); // ovf + grant
      // Flush: request still granted in the flush-raise cycle, then 5 blocked cycles.
      row(1, 4'b0001, 8'b0000_0000, 1, 1, 4'b0001,  7, 0, 0, 0, 8'b0000_0000, 30, 1);
      row(1, 4'b0001, 8'b0000_0000, 1, 0, 4'b0000,  0, 0, 0, 0, 8'b0000_0000, 30, 1);
      row(1, 4'b0001, 8'b0000_0000, 1, 0, 4'b0000,  0, 0, 0, 0, 8'b0000_0000, 30, 1);
      row(1, 4'b0001, 8'b0000_0001, 0, 0, 4'b0000,  0, 0, 0, 0, 8'b0000_0001, 31, 1);
      row(1, 4'b0001, 8'b0000_0000, 0, 0, 4'b0000,  0, 0, 0, 0, 8'b0000_0000, 31, 1);
      row(1, 4'b0001, 8'b0000_0000, 0, 0, 4'b0000,  0, 0, 0, 0, 8'b0000_0000, 31, 1);
      row(1, 4'b0001, 8'b0000_0000, 0, 1, 4'b0001,  7, 0, 0, 0, 8'b0000_0000, 30, 1);

      // Reset held two cycles with busy inputs: outputs quiet, count full.
      rst = 1'b1; flush = 1'b0;
      alloc_valid = 1'b1; alloc_req = 4'b1111; free_valid = 8'hFF;
      @(posedge clk); @(posedge clk); #1;
      check("rst_ready",  32'(alloc_ready), 32'd0);
      check("rst_rd_en",  32'(fl_rd_en),    32'd0);
      check("rst_wr_en",  32'(fl_wr_en),    32'd0);
      check("rst_tags",   32'({alloc_tag3, alloc_tag2, alloc_tag1, alloc_tag0}), 32'd0);
      check("rst_count",  32'(free_count),  32'd32);
      check("rst_err",    32'(err_overflow), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         alloc_valid = vecs[i].av;
         alloc_req   = vecs[i].req;
         free_valid  = vecs[i].fv;
         flush       = vecs[i].fl;
         #3;
         check($sformatf("v%0d_ready", i), 32'(alloc_ready), 32'(vecs[i].rdy));
         check($sformatf("v%0d_rd_en", i), 32'(fl_rd_en),    32'(vecs[i].rd));
         check($sformatf("v%0d_tags", i),
               32'({alloc_tag3, alloc_tag2, alloc_tag1, alloc_tag0}), 32'(vecs[i].tags));
         check($sformatf("v%0d_wr_en", i), 32'(fl_wr_en),    32'(vecs[i].wr));
         if ({fl_wdata7, fl_wdata6, fl_wdata5, fl_wdata4, fl_wdata3, fl_wdata2, fl_wdata1, fl_wdata0}
             !== exp_wdata(vecs[i].fv, i != 0)) begin
            failures++;
            $display("FAIL v%0d_wdata: got 0x%0h expected 0x%0h", i,
                     {fl_wdata7, fl_wdata6, fl_wdata5, fl_wdata4,
                      fl_wdata3, fl_wdata2, fl_wdata1, fl_wdata0},
                     exp_wdata(vecs[i].fv, i != 0));
         end
         checks++;
         @(posedge clk); #1;
         check($sformatf("v%0d_count", i), 32'(free_count),   32'(vecs[i].cnt));
         check($sformatf("v%0d_err", i),   32'(err_overflow), 32'(vecs[i].err));
      end

      // Mid-operation reset with an in-flight request: grant discarded,
      // count restored, sticky error cleared, then INIT blocks one cycle.
      rst = 1'b1; flush = 1'b0;
      alloc_valid = 1'b1; alloc_req = 4'b1111; free_valid = 8'b0000_0001;
      @(posedge clk); #1;
      check("midrst_count", 32'(free_count),   32'd32);
      check("midrst_err",   32'(err_overflow), 32'd0);
      rst = 1'b0; free_valid = 8'h00;
      #3;
      check("midrst_init_ready", 32'(alloc_ready), 32'd0);
      @(posedge clk); #1;
      check("midrst_init_count", 32'(free_count), 32'd32);
      #2;
      check("midrst_run_ready", 32'(alloc_ready), 32'd1);
      check("midrst_run_rd_en", 32'(fl_rd_en),    32'(4'b1111));
      @(posedge clk); #1;
      check("midrst_run_count", 32'(free_count), 32'd28);

      // Flush raised during recovery restarts the flush sequence.
      flush = 1'b1; alloc_req = 4'b0001;
      @(posedge clk); #1;           // RUN -> FLUSH
      flush = 1'b0;
      @(posedge clk); #1;           // FLUSH -> REC1
      flush = 1'b1;
      @(posedge clk); #1;           // REC1 -> FLUSH
      flush = 1'b0;
      @(posedge clk); #1;           // FLUSH -> REC1
      @(posedge clk); #1;           // REC1 -> REC2
      #2;
      check("reflush_rec2_ready", 32'(alloc_ready), 32'd0);
      @(posedge clk); #1;           // REC2 -> RUN
      #2;
      check("reflush_run_ready", 32'(alloc_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
